// File: rtl/rng_pkg.sv
// rng_pkg: shared states, LFSR taps, default seed and step function for the RNG scheduler
package rng_pkg;
  typedef enum logic [3:0] {
    S_INI   = 4'b0001,
    S_IDLE  = 4'b0010,
    S_GEN   = 4'b0100,
    S_GRANT = 4'b1000
  } state_t;
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;
  localparam logic [15:0] DEF_SEED = 16'hACE1;
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D]};
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR with synchronous load and shift enable
module lfsr16
  import rng_pkg::*;
#(
  parameter logic [15:0] SEED = DEF_SEED
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        shift,
  output logic [15:0] q
);
  // load wins over shift; the register holds when neither is asserted
  always_ff @(posedge Clk)
    if (Reset) q <= SEED;
    else if (load) q <= seed;
    else if (shift) q <= lfsr_next(q);
endmodule

// File: rtl/rng_scheduler.sv
// rng_scheduler: round-robin sharing of one entropy-seeded LFSR among NREQ requesters
module rng_scheduler
  import rng_pkg::*;
#(
  parameter int          NREQ  = 4,
  parameter int          WIDTH = 4,
  parameter int          STEPS = 4,
  parameter logic [15:0] SEED  = DEF_SEED
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       I,
  input  logic             Start,
  input  logic [NREQ-1:0]  Req,
  output logic [NREQ-1:0]  Gnt,
  output logic             Valid,
  output logic [WIDTH-1:0] Rnd,
  output logic             Ready,
  output logic             Busy
);
  localparam int WW = $clog2(NREQ);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, step_q, step_d;
  logic [1:0] i_prev_q;
  logic [WW-1:0] win_q, win_d, last_q, last_d;
  logic [WIDTH-1:0] rnd_q, rnd_d;
  logic [15:0] lfsr_q, mix, seed_mix;
  logic load, shift;
  function automatic logic [WW-1:0] rr_pick(input logic [NREQ-1:0] req, input logic [WW-1:0] last);
    logic [WW-1:0] w;
    w = last;
    for (int k = NREQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) w = WW'(idx);
    end
    return w;
  endfunction
  assign mix = SEED ^ {12'h000, cnt_q};
  assign seed_mix = (mix == 16'h0000) ? 16'h0001 : mix;
  lfsr16 #(.SEED(SEED)) u_lfsr (
    .Clk(Clk), .Reset(Reset), .load(load), .seed(seed_mix), .shift(shift), .q(lfsr_q)
  );
  // next-state: seeding in INI, arbitration in IDLE, STEPS shifts in GEN, bookkeeping in GRANT
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == S_INI && I != i_prev_q) ? cnt_q + 4'd1 : cnt_q;
    step_d = step_q;
    win_d = win_q;
    last_d = last_q;
    rnd_d = rnd_q;
    load = 1'b0;
    shift = 1'b0;
    case (state_q)
      S_INI: if (Start) begin
        load = 1'b1;
        state_d = S_IDLE;
      end
      S_IDLE: if (|Req) begin
        win_d = rr_pick(Req, last_q);
        step_d = 4'd0;
        state_d = S_GEN;
      end
      S_GEN: begin
        shift = 1'b1;
        step_d = step_q + 4'd1;
        if (step_q == 4'(STEPS - 1)) begin
          rnd_d = WIDTH'(lfsr_next(lfsr_q));
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        last_d = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_INI;
    endcase
  end
  // state registers; the previous input sample is refreshed every cycle, even in reset
  always_ff @(posedge Clk) begin
    i_prev_q <= I;
    if (Reset) begin
      state_q <= S_INI;
      cnt_q <= 4'd0;
      step_q <= 4'd0;
      win_q <= '0;
      last_q <= WW'(NREQ - 1);
      rnd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      step_q <= step_d;
      win_q <= win_d;
      last_q <= last_d;
      rnd_q <= rnd_d;
    end
  end
  assign Valid = state_q == S_GRANT;
  assign Gnt = Valid ? NREQ'(1) << win_q : '0;
  assign Rnd = rnd_q;
  assign Ready = state_q != S_INI;
  assign Busy = state_q == S_GEN || state_q == S_GRANT;
endmodule

// File: tb/tb_rng_scheduler.sv
// tb_rng_scheduler: directed checks of seeding, round-robin order, draw timing and reset abort
module tb_rng_scheduler;
  logic Clk = 1'b0, Reset, Start, Valid, Ready, Busy;
  logic [1:0] I;
  logic [3:0] Req, Gnt, Rnd;
  logic [15:0] m;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    int lat;
  } vec_t;
  vec_t tbl[5];
  rng_scheduler #(.NREQ(4), .WIDTH(4), .STEPS(4), .SEED(16'hACE1)) u_dut (
    .Clk(Clk), .Reset(Reset), .I(I), .Start(Start), .Req(Req), .Gnt(Gnt),
    .Valid(Valid), .Rnd(Rnd), .Ready(Ready), .Busy(Busy)
  );
  always #5 Clk = ~Clk;
  function automatic logic [15:0] step4(input logic [15:0] q);
    for (int s = 0; s < 4; s++) q = {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    return q;
  endfunction
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic draw(input string nm, input logic [3:0] req, input logic [3:0] gnt, input int lat, input logic drop);
    int n;
    n = 0;
    Req = req;
    do begin
      tick;
      n++;
      if (drop && n == 1) Req = 4'b0000;
    end while (!Valid && n < 20);
    m = step4(m);
    chk({nm, "_lat"}, n, lat);
    chk({nm, "_gnt"}, Gnt, gnt);
    chk({nm, "_rnd"}, Rnd, m[3:0]);
    chk({nm, "_lfsr"}, u_dut.u_lfsr.q, m);
  endtask
  initial begin
    int nv;
    tbl[0] = '{4'b1111, 4'b0001, 5};
    tbl[1] = '{4'b1111, 4'b0010, 6};
    tbl[2] = '{4'b1111, 4'b0100, 6};
    tbl[3] = '{4'b1111, 4'b1000, 6};
    tbl[4] = '{4'b1111, 4'b0001, 6};
    Reset = 1'b1; Start = 1'b0; I = 2'd0; Req = 4'b0000;
    tick; tick;
    chk("rst_gnt", Gnt, 0); chk("rst_valid", Valid, 0); chk("rst_rnd", Rnd, 0);
    chk("rst_ready", Ready, 0); chk("rst_busy", Busy, 0); chk("rst_lfsr", u_dut.u_lfsr.q, 16'hACE1);
    Reset = 1'b0;
    Start = 1'b1; tick; Start = 1'b0;
    chk("seed_ready", Ready, 1); chk("seed_lfsr", u_dut.u_lfsr.q, 16'hACE1);
    m = 16'hACE1;
    draw("first", 4'b0001, 4'b0001, 5, 1'b0);
    chk("first_rnd_const", Rnd, 4'hE); chk("first_lfsr_const", u_dut.u_lfsr.q, 16'hCE1E);
    Req = 4'b0000; tick;
    chk("first_valid_pulse", Valid, 0); chk("first_idle_busy", Busy, 0);
    draw("rr_drop", 4'b0101, 4'b0100, 5, 1'b1);
    Req = 4'b0000; tick;
    draw("rr_next", 4'b0101, 4'b0001, 5, 1'b0);
    Req = 4'b0000; tick;
    Start = 1'b1; tick; Start = 1'b0;
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      I = I + 2'd1;
      tick;
      if (Valid) nv++;
    end
    chk("idle_lfsr", u_dut.u_lfsr.q, m); chk("idle_novalid", nv, 0);
    chk("idle_cnt", u_dut.cnt_q, 0); chk("idle_ready", Ready, 1);
    I = 2'd0; Req = 4'b0001;
    tick; tick;
    chk("gen_busy", Busy, 1);
    Reset = 1'b1; tick; Reset = 1'b0;
    chk("abort_gnt", Gnt, 0); chk("abort_valid", Valid, 0); chk("abort_ready", Ready, 0);
    chk("abort_rnd", Rnd, 0); chk("abort_busy", Busy, 0);
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (Valid) nv++;
    end
    chk("abort_nogrant", nv, 0); chk("abort_still_ini", Ready, 0);
    Req = 4'b0000;
    I = 2'd1; tick; I = 2'd2; tick; I = 2'd3; tick;
    chk("ent_cnt", u_dut.cnt_q, 3);
    Start = 1'b1; tick; Start = 1'b0;
    chk("ent_lfsr", u_dut.u_lfsr.q, 16'hACE2);
    m = 16'hACE2;
    for (int v = 0; v < 5; v++) draw($sformatf("rr_all%0d", v), tbl[v].req, tbl[v].gnt, tbl[v].lat, 1'b0);
    Req = 4'b0000; tick;
    chk("rr_all_end_valid", Valid, 0); chk("rr_all_end_gnt", Gnt, 0);
    tick;
    chk("rr_all_end_busy", Busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rng_scheduler.md
# rng_scheduler

Shares one seeded 16-bit LFSR random source among up to NREQ game requesters, such as enemy spawn, item drop and AI move logic. The LFSR seed comes from the number of player-input transitions seen before `Start`. Requests are served in round-robin order. Each grant delivers a fresh WIDTH-bit value after STEPS LFSR shifts. Sits between the player-input synchroniser and the game-logic consumers.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 4, bits of random value delivered per grant (1..16)
- STEPS, 4, LFSR shifts per draw (1..15)
- SEED, 16'hACE1, base seed; must be nonzero
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- I  in  2  player input, already synchronised; transitions are entropy
- Start  in  1  one-cycle pulse; seeds the LFSR and leaves INI
- Req  in  NREQ  level request per requester; held until granted
- Gnt  out  NREQ  one-hot grant, one-cycle pulse
- Valid  out  1  high in the same cycle as Gnt
- Rnd  out  WIDTH  delivered value; held until the next grant
- Ready  out  1  high once seeded (state != INI)
- Busy  out  1  high in GEN and GRANT

## Operation
- Reset values: Gnt=0, Valid=0, Rnd=0, Ready=0, Busy=0, state=INI, cnt=0, I_prev=I, LFSR=SEED, rr_last=NREQ-1.
- Entropy counter `cnt` (4-bit) increments whenever I != I_prev in INI. It wraps 15→0. I_prev is updated every cycle in all states.
- LFSR is Fibonacci, polynomial x^16+x^14+x^13+x^11+1:
  - fb = q[15]^q[13]^q[12]^q[10]
  - q <= {q[14:0], fb}
- FSM states: INI, IDLE, GEN, GRANT. Encoding is one-hot.
- INI: on Start, load q = SEED ^ {12'h000, cnt} and go to IDLE. If the loaded value would be 0, load 16'h0001. Start is ignored in every other state.
- IDLE: if Req != 0, select the winner round-robin, latch it, clear step_cnt and go to GEN. Otherwise stay in IDLE.
- Round-robin selection: the first set Req index searching upward from rr_last+1, wrapping at NREQ.
- GEN: shift the LFSR once per cycle and increment step_cnt. After the STEPS-th shift go to GRANT.
- GRANT: Gnt[winner]=1, Valid=1, Rnd <= q[WIDTH-1:0] (post-shift value), rr_last <= winner. Return to IDLE.
- A committed draw completes even if the winner drops Req during GEN.
- Req changes during GEN or GRANT have no effect until the next IDLE.
- A winner that keeps Req high is re-arbitrated behind every other active requester.
- Reset at any point aborts the draw. Outputs return to reset values on the next edge and any pending grant is lost.
- The LFSR never shifts in INI or IDLE.

## Timing
- Req sampled high in IDLE at cycle t → GEN at t+1..t+STEPS → Gnt/Valid at cycle t+STEPS+1.
- Back-to-back draws: next IDLE at t+STEPS+2. Throughput is one grant per STEPS+2 cycles.
- Rnd updates on the edge entering GRANT and is stable from the Valid cycle onward.
- Start at cycle t → Ready=1 at t+1.

## Structure
- Shared package `rng_pkg` holds:
  - the state localparams (S_INI, S_IDLE, S_GEN, S_GRANT)
  - the LFSR tap positions
  - the default SEED
- Sub-module `lfsr16`: ports Clk, Reset, load, seed[15:0], shift, q[15:0]. It is instantiated once.
- Round-robin selection is a combinational function inside `rng_scheduler`.

## Test plan
- Reset, then Start with no I changes, then Req=4'b0001 → Gnt=4'b0001 and Valid 5 cycles after IDLE sampling, Rnd=4'hE, internal LFSR=16'hCE1E.
- Three I transitions in INI, then Start → LFSR loaded with 16'hACE2. Rnd matches the reference model.
- Req=4'b1111 held continuously → grant order 0,1,2,3,0, one grant every 6 cycles, Valid exactly one cycle each.
- Winner drops Req during GEN → grant still pulses. Req=4'b0101 with rr_last=0 → requester 2 is granted before 0.
- Reset asserted in GEN → next cycle Gnt=0, Valid=0, Ready=0, Rnd=0. Start is required again before any grant.
- Start pulsed in IDLE, Req=0 for 20 cycles → LFSR unchanged and no Valid; cnt does not increment on I toggles after seeding.
